// File: rtl/sipo_feeder.sv
// -----------------------------------------------------------------------------
// sipo_feeder
//   Sits in front of a free-running SIPO shift register, which shifts every
//   clock and has no load enable. Words arrive on an irregular valid/ready
//   stream and are buffered in a FIFO. Words are only released as gap-free
//   bursts of exactly FRAME words, so the SIPO parallel output holds one
//   complete, aligned frame. frame_valid marks the single cycle in which
//   that frame is present on the SIPO p_out.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset (highest priority)
//   in_data      in   upstream word
//   in_valid     in   upstream word valid
//   in_ready     out  FIFO can accept a word this cycle (from registered count)
//   hold         in   downstream stall; only blocks the launch of a new burst
//   s_out        out  serial word to the SIPO input, registered (0 when idle)
//   s_active     out  s_out carries a burst word this cycle, registered
//   frame_valid  out  SIPO p_out holds a complete frame this cycle, registered
//   fifo_count   out  FIFO occupancy, registered
// -----------------------------------------------------------------------------
module sipo_feeder #(
  parameter int WORD_W = 32,
  parameter int FRAME  = 4,
  parameter int DEPTH  = 2 * FRAME,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              hold,
  output logic [WORD_W-1:0] s_out,
  output logic              s_active,
  output logic              frame_valid,
  output logic [CNT_W-1:0]  fifo_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int K_W   = (FRAME > 1) ? $clog2(FRAME) : 1;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] FRAME_C  = CNT_W'(FRAME);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(FRAME - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [K_W-1:0]    r_k;
  logic [K_W-1:0]    w_k_nxt;

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_nxt;

  logic              w_in_ready;
  logic              w_push;
  logic              w_pop;
  logic              w_last_pop;

  logic [WORD_W-1:0] r_s_out;
  logic              r_s_active;
  logic              r_last_pop_d;
  logic              r_frame_valid;

  // Circular pointer advance; DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_LAST) begin
      ptr_inc = {PTR_W{1'b0}};
    end else begin
      ptr_inc = ptr + PTR_W'(1);
    end
  endfunction

  // A pop in the same cycle never frees a slot: ready looks only at the
  // registered occupancy.
  assign w_in_ready = (r_count < DEPTH_C);
  assign w_push     = in_valid && w_in_ready;

  // Burst control: launch only with a full frame resident and no hold; once
  // started, a burst runs to completion regardless of hold because the SIPO
  // cannot pause.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE:  w_pop = (r_count >= FRAME_C) && !hold;
      ST_BURST: w_pop = 1'b1;
      default:  w_pop = 1'b0;
    endcase
    if (w_pop) begin
      if (r_k == K_LAST) begin
        w_state_nxt = ST_IDLE;
        w_k_nxt     = {K_W{1'b0}};
      end else begin
        w_state_nxt = ST_BURST;
        w_k_nxt     = r_k + K_W'(1);
      end
    end else begin
      w_state_nxt = r_state;
      w_k_nxt     = r_k;
    end
  end

  assign w_last_pop = w_pop && (r_k == K_LAST);

  // Occupancy update: simultaneous push and pop cancel out.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Burst state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_k     <= {K_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
    end
  end

  // FIFO pointers and occupancy; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      r_count <= w_count_nxt;
    end
  end

  // FIFO storage; contents are don't-care outside the pointer window.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // Serial output stage. frame_valid trails the last pop by two cycles: one
  // for s_out registration, one for the SIPO to capture the final word.
  // Reset clears the pipeline so an aborted burst never signals a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_out       <= {WORD_W{1'b0}};
      r_s_active    <= 1'b0;
      r_last_pop_d  <= 1'b0;
      r_frame_valid <= 1'b0;
    end else begin
      r_s_out       <= w_pop ? r_mem[r_rd_ptr] : {WORD_W{1'b0}};
      r_s_active    <= w_pop;
      r_last_pop_d  <= w_last_pop;
      r_frame_valid <= r_last_pop_d;
    end
  end

  assign in_ready    = w_in_ready;
  assign s_out       = r_s_out;
  assign s_active    = r_s_active;
  assign frame_valid = r_frame_valid;
  assign fifo_count  = r_count;

endmodule

// File: tb/tb_sipo_feeder.sv
// -----------------------------------------------------------------------------
// tb_sipo_feeder
//   Directed bench for sipo_feeder with FRAME=4, WORD_W=32, DEPTH=8. A plain
//   4-word shift register models the downstream SIPO so frame contents can be
//   checked on the frame_valid cycle. Within each scenario, "cycle 0" is the
//   first cycle after the scenario starts; inputs set in cycle c are sampled
//   at the rising edge that ends cycle c.
// -----------------------------------------------------------------------------
module tb_sipo_feeder;

  localparam int WORD_W = 32;
  localparam int FRAME  = 4;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [WORD_W-1:0]       in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic                    hold;
  logic [WORD_W-1:0]       s_out;
  logic                    s_active;
  logic                    frame_valid;
  logic [CNT_W-1:0]        fifo_count;
  logic [FRAME*WORD_W-1:0] p_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sipo_feeder #(
    .WORD_W(WORD_W),
    .FRAME (FRAME),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .hold       (hold),
    .s_out      (s_out),
    .s_active   (s_active),
    .frame_valid(frame_valid),
    .fifo_count (fifo_count)
  );

  // Downstream SIPO: shifts every clock, newest word enters at the bottom.
  always_ff @(posedge clk) begin
    p_out <= {p_out[(FRAME-1)*WORD_W-1:0], s_out};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; hold = 1'b0; in_data = '0;
    step(); step();
    n_checks++; if (s_out !== 32'h0) begin n_fail++; $display("FAIL reset_s_out: got %h expected %h", s_out, 32'h0); end
    n_checks++; if (s_active !== 1'b0) begin n_fail++; $display("FAIL reset_s_active: got %b expected 0", s_active); end
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_frame_valid: got %b expected 0", frame_valid); end
    n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL reset_fifo_count: got %0d expected 0", fifo_count); end
    rst = 1'b0;
    step();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (s_active !== 1'b0) begin n_fail++; $display("FAIL reset_idle_s_active: got %b expected 0", s_active); end
    n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL reset_idle_count: got %0d expected 0", fifo_count); end
  endtask

  // Push A0..A3 on cycles 0..3: pops 4..7, s_out 5..8, frame_valid on 9.
  task automatic test_single_frame();
    logic [WORD_W-1:0] a [4];
    logic [WORD_W-1:0] exp_out;
    logic              exp_act;
    for (int i = 0; i < 4; i++) a[i] = 32'hA000_0000 + 32'(i);
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 4);
      in_data  = (c < 4) ? a[c] : 32'h0;
      exp_act  = (c >= 5) && (c <= 8);
      exp_out  = exp_act ? a[c-5] : 32'h0;
      n_checks++; if (s_active !== exp_act) begin n_fail++; $display("FAIL single_s_active c%0d: got %b expected %b", c, s_active, exp_act); end
      n_checks++; if (s_out !== exp_out) begin n_fail++; $display("FAIL single_s_out c%0d: got %h expected %h", c, s_out, exp_out); end
      n_checks++; if (frame_valid !== (c == 9)) begin n_fail++; $display("FAIL single_frame_valid c%0d: got %b expected %b", c, frame_valid, (c == 9)); end
      if (c == 4) begin
        n_checks++; if (fifo_count !== 4'd4) begin n_fail++; $display("FAIL single_count_c4: got %0d expected 4", fifo_count); end
      end
      if (c == 9) begin
        n_checks++; if (p_out !== {a[0], a[1], a[2], a[3]}) begin n_fail++; $display("FAIL single_p_out: got %h expected %h", p_out, {a[0], a[1], a[2], a[3]}); end
        n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL single_count_c9: got %0d expected 0", fifo_count); end
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  // B0..B2 on cycles 0..2, B3 on cycle 9: pops 10..13, s_out 11..14, fv 15.
  task automatic test_partial_frame();
    logic [WORD_W-1:0] b [4];
    logic [WORD_W-1:0] exp_out;
    logic              exp_act;
    int                fv_cnt = 0;
    for (int i = 0; i < 4; i++) b[i] = 32'hB000_0010 + 32'(i);
    for (int c = 0; c < 19; c++) begin
      in_valid = (c < 3) || (c == 9);
      in_data  = (c < 3) ? b[c] : ((c == 9) ? b[3] : 32'h0);
      exp_act  = (c >= 11) && (c <= 14);
      exp_out  = exp_act ? b[c-11] : 32'h0;
      n_checks++; if (s_active !== exp_act) begin n_fail++; $display("FAIL partial_s_active c%0d: got %b expected %b", c, s_active, exp_act); end
      n_checks++; if (s_out !== exp_out) begin n_fail++; $display("FAIL partial_s_out c%0d: got %h expected %h", c, s_out, exp_out); end
      if (frame_valid) fv_cnt++;
      if (c == 15) begin
        n_checks++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL partial_fv_c15: got %b expected 1", frame_valid); end
        n_checks++; if (p_out !== {b[0], b[1], b[2], b[3]}) begin n_fail++; $display("FAIL partial_p_out: got %h expected %h", p_out, {b[0], b[1], b[2], b[3]}); end
      end
      if (c == 8) begin
        n_checks++; if (fifo_count !== 4'd3) begin n_fail++; $display("FAIL partial_count_c8: got %0d expected 3", fifo_count); end
      end
      step();
    end
    in_valid = 1'b0;
    n_checks++; if (fv_cnt != 1) begin n_fail++; $display("FAIL partial_fv_count: got %0d expected 1", fv_cnt); end
  endtask

  // C0..C7 on cycles 0..7: pops 4..11 gap-free, s_out 5..12, fv on 9 and 13.
  task automatic test_back_to_back();
    logic [WORD_W-1:0] w [8];
    logic [WORD_W-1:0] exp_out;
    logic              exp_act;
    for (int i = 0; i < 8; i++) w[i] = 32'hC0C0_0100 + 32'(i);
    for (int c = 0; c < 17; c++) begin
      in_valid = (c < 8);
      in_data  = (c < 8) ? w[c] : 32'h0;
      exp_act  = (c >= 5) && (c <= 12);
      exp_out  = exp_act ? w[c-5] : 32'h0;
      n_checks++; if (s_active !== exp_act) begin n_fail++; $display("FAIL b2b_s_active c%0d: got %b expected %b", c, s_active, exp_act); end
      n_checks++; if (s_out !== exp_out) begin n_fail++; $display("FAIL b2b_s_out c%0d: got %h expected %h", c, s_out, exp_out); end
      n_checks++; if (frame_valid !== ((c == 9) || (c == 13))) begin n_fail++; $display("FAIL b2b_frame_valid c%0d: got %b expected %b", c, frame_valid, ((c == 9) || (c == 13))); end
      if (c == 8) begin
        n_checks++; if (fifo_count !== 4'd4) begin n_fail++; $display("FAIL b2b_count_c8: got %0d expected 4", fifo_count); end
      end
      if (c == 9) begin
        n_checks++; if (p_out !== {w[0], w[1], w[2], w[3]}) begin n_fail++; $display("FAIL b2b_p_out_1: got %h expected %h", p_out, {w[0], w[1], w[2], w[3]}); end
      end
      if (c == 13) begin
        n_checks++; if (p_out !== {w[4], w[5], w[6], w[7]}) begin n_fail++; $display("FAIL b2b_p_out_2: got %h expected %h", p_out, {w[4], w[5], w[6], w[7]}); end
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  // hold=1 while 12 words are offered: FIFO fills at 8 on cycle 8. Release on
  // cycle 11: pops 11..22 in three bursts, D8..D11 accepted on 12..15. hold is
  // raised again on cycle 20, inside the third burst, which still completes.
  task automatic test_hold_full();
    logic [WORD_W-1:0] d [12];
    int                idx_in  = 0;
    int                idx_out = 0;
    int                fv_cnt  = 0;
    logic              acc;
    for (int i = 0; i < 12; i++) d[i] = 32'hD00D_0200 + 32'(i);
    for (int c = 0; c < 30; c++) begin
      hold     = (c < 11) || (c >= 20);
      in_valid = (idx_in < 12);
      in_data  = (idx_in < 12) ? d[idx_in] : 32'h0;
      if (c == 8) begin
        n_checks++; if (fifo_count !== 4'd8) begin n_fail++; $display("FAIL hold_count_full: got %0d expected 8", fifo_count); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready_full: got %b expected 0", in_ready); end
      end
      if (c == 11) begin
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready_release: got %b expected 0", in_ready); end
      end
      if (c == 12) begin
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_in_ready_c12: got %b expected 1", in_ready); end
      end
      if (c <= 11) begin
        n_checks++; if (s_active !== 1'b0) begin n_fail++; $display("FAIL hold_no_launch c%0d: got %b expected 0", c, s_active); end
      end
      if ((c >= 12) && (c <= 23)) begin
        n_checks++; if (s_active !== 1'b1) begin n_fail++; $display("FAIL hold_drain_active c%0d: got %b expected 1", c, s_active); end
      end
      if (c == 24) begin
        n_checks++; if (s_active !== 1'b0) begin n_fail++; $display("FAIL hold_end_active: got %b expected 0", s_active); end
        n_checks++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL hold_last_fv: got %b expected 1", frame_valid); end
      end
      if (s_active === 1'b1) begin
        n_checks++;
        if (idx_out >= 12) begin
          n_fail++; $display("FAIL hold_extra_word: got %h expected no word", s_out);
        end else if (s_out !== d[idx_out]) begin
          n_fail++; $display("FAIL hold_order #%0d: got %h expected %h", idx_out, s_out, d[idx_out]);
        end
        idx_out++;
      end
      if (frame_valid === 1'b1) fv_cnt++;
      acc = in_valid && in_ready;
      step();
      if (acc) idx_in++;
    end
    in_valid = 1'b0;
    hold     = 1'b0;
    n_checks++; if (idx_in != 12) begin n_fail++; $display("FAIL hold_accepted: got %0d expected 12", idx_in); end
    n_checks++; if (idx_out != 12) begin n_fail++; $display("FAIL hold_delivered: got %0d expected 12", idx_out); end
    n_checks++; if (fv_cnt != 3) begin n_fail++; $display("FAIL hold_fv_count: got %0d expected 3", fv_cnt); end
    n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL hold_final_count: got %0d expected 0", fifo_count); end
  endtask

  // E0..E3 on cycles 0..3; rst in cycle 6 while E1 is on s_out.
  task automatic test_reset_mid();
    logic [WORD_W-1:0] e [4];
    for (int i = 0; i < 4; i++) e[i] = 32'hEEEE_0300 + 32'(i);
    for (int c = 0; c < 16; c++) begin
      in_valid = (c < 4);
      in_data  = (c < 4) ? e[c] : 32'h0;
      rst      = (c == 6);
      if (c == 6) begin
        n_checks++; if (s_out !== e[1]) begin n_fail++; $display("FAIL rmid_second_word: got %h expected %h", s_out, e[1]); end
      end
      if (c == 7) begin
        n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL rmid_count: got %0d expected 0", fifo_count); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready: got %b expected 1", in_ready); end
      end
      if (c >= 7) begin
        n_checks++; if (s_active !== 1'b0) begin n_fail++; $display("FAIL rmid_s_active c%0d: got %b expected 0", c, s_active); end
        n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_frame_valid c%0d: got %b expected 0", c, frame_valid); end
      end
      step();
    end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  // F0..F3 on cycles 0..3, last pop on 7; rst in cycle 8 must cancel the
  // frame_valid that would otherwise appear in cycle 9.
  task automatic test_reset_late();
    logic [WORD_W-1:0] f [4];
    for (int i = 0; i < 4; i++) f[i] = 32'hF00F_0400 + 32'(i);
    for (int c = 0; c < 14; c++) begin
      in_valid = (c < 4);
      in_data  = (c < 4) ? f[c] : 32'h0;
      rst      = (c == 8);
      if (c == 8) begin
        n_checks++; if (s_out !== f[3]) begin n_fail++; $display("FAIL rlate_last_word: got %h expected %h", s_out, f[3]); end
      end
      if (c >= 9) begin
        n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL rlate_frame_valid c%0d: got %b expected 0", c, frame_valid); end
      end
      step();
    end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; hold = 1'b0; in_data = '0;
    test_reset();
    test_single_frame();
    test_partial_frame();
    test_back_to_back();
    test_hold_full();
    test_reset_mid();
    test_reset_late();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
